// File: rtl/cordic_nco_if.sv
// Signal bundle between the NCO front end and its surroundings: phase control,
// CORDIC core drive/return, and the corrected sin/cos output.
interface cordic_nco_if #(
   parameter int PHASE_W = 32
);
   logic               en;
   logic               load;
   logic [PHASE_W-1:0] phase_init;
   logic [PHASE_W-1:0] phase_inc;
   logic [15:0]        x_in;
   logic [15:0]        y_in;
   logic [15:0]        theta_in;
   logic [15:0]        sinx_raw;
   logic [15:0]        cosx_raw;
   logic [15:0]        sin_out;
   logic [15:0]        cos_out;
   logic               out_valid;

   modport master (
      output en, load, phase_init, phase_inc, sinx_raw, cosx_raw,
      input  x_in, y_in, theta_in, sin_out, cos_out, out_valid
   );

   modport slave (
      input  en, load, phase_init, phase_inc, sinx_raw, cosx_raw,
      output x_in, y_in, theta_in, sin_out, cos_out, out_valid
   );
endinterface

// File: rtl/cordic_nco_frontend.sv
// NCO front end for a pipelined CORDIC core: phase accumulation, quadrant fold,
// latency-matched sign correction. Define CORDIC_NCO_ROUND_EN to round theta.
module cordic_nco_frontend #(
   parameter int          PHASE_W = 32,
   parameter int          LATENCY = 16,
   parameter logic [15:0] XINIT   = 16'h26DD
) (
   input logic         clk,
   input logic         rst,
   cordic_nco_if.slave bus
);

   logic [PHASE_W-1:0] phase_acc_q, phase_acc_d;
   logic [15:0]        theta_q, theta_d;
   logic [LATENCY:0]   flag_q, flag_d;
   logic [LATENCY:0]   tag_q, tag_d;
   logic [15:0]        sin_q, sin_d;
   logic [15:0]        cos_q, cos_d;
   logic               valid_q, valid_d;

   logic [15:0]        p;
   logic [15:0]        a_fold;
   logic               fold_flag;
   logic               take;
   logic signed [31:0] prod;
   logic [15:0]        theta_calc;

   function automatic logic [15:0] neg_sat(input logic [15:0] v);
      return (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
   endfunction

   // Quadrants 01/10 are rotated by pi into [-pi/2, pi/2); the flag undoes it later.
   always_comb begin
      p          = phase_acc_q[PHASE_W-1 -: 16];
      fold_flag  = p[15] ^ p[14];
      a_fold     = fold_flag ? {~p[15], p[14:0]} : p;
      prod       = 32'($signed(a_fold)) * 32'sd25736;
`ifdef CORDIC_NCO_ROUND_EN
      prod       = prod + 32'sd8192;
`endif
      theta_calc = 16'(prod >>> 14);
   end

   always_comb begin
      phase_acc_d = phase_acc_q;
      theta_d     = theta_q;
      take        = 1'b0;
      if (bus.load) begin
         phase_acc_d = bus.phase_init;
      end else if (bus.en) begin
         take        = 1'b1;
         theta_d     = theta_calc;
         phase_acc_d = phase_acc_q + bus.phase_inc;
      end
      flag_d  = {flag_q[LATENCY-1:0], take & fold_flag};
      tag_d   = {tag_q[LATENCY-1:0], take};
      // The core free-runs, so the outputs track it even for untagged slots.
      sin_d   = flag_q[LATENCY] ? neg_sat(bus.sinx_raw) : bus.sinx_raw;
      cos_d   = flag_q[LATENCY] ? neg_sat(bus.cosx_raw) : bus.cosx_raw;
      valid_d = tag_q[LATENCY];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_acc_q <= '0;
         theta_q     <= '0;
         flag_q      <= '0;
         tag_q       <= '0;
         sin_q       <= '0;
         cos_q       <= '0;
         valid_q     <= 1'b0;
      end else begin
         phase_acc_q <= phase_acc_d;
         theta_q     <= theta_d;
         flag_q      <= flag_d;
         tag_q       <= tag_d;
         sin_q       <= sin_d;
         cos_q       <= cos_d;
         valid_q     <= valid_d;
      end
   end

   assign bus.x_in      = XINIT;
   assign bus.y_in      = 16'h0000;
   assign bus.theta_in  = theta_q;
   assign bus.sin_out   = sin_q;
   assign bus.cos_out   = cos_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_cordic_nco_frontend.sv
// Self-checking bench for cordic_nco_frontend: vector table plus hand sequences,
// with a scoreboard keyed on the expected output edge.
`timescale 1ns/1ps
module tb_cordic_nco_frontend;
   localparam int PW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cordic_nco_if #(.PHASE_W(PW)) bus ();

   cordic_nco_frontend #(.PHASE_W(PW), .LATENCY(16), .XINIT(16'h26DD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          exp_edge;
      logic [15:0] s;
      logic [15:0] c;
   } sb_t;

   typedef struct {
      logic [31:0] pinit;
      logic [15:0] sr, cr, et, es, ec;
   } vec_t;

   sb_t         sb_q[$];
   sb_t         mon_e;
   vec_t        tbl[8];
   int          checks = 0;
   int          errors = 0;
   int          edge_n = 0;
   logic [31:0] m_phase;
   logic [15:0] m_theta;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic int fold_a(input logic [15:0] p);
      int ps;
      ps = int'($signed(p));
      if (ps >= 16384)       return ps - 32768;
      else if (ps < -16384)  return ps + 32768;
      else                   return ps;
   endfunction

   function automatic logic fold_f(input logic [15:0] p);
      int ps;
      ps = int'($signed(p));
      return (ps >= 16384) || (ps < -16384);
   endfunction

   function automatic logic [15:0] model_theta(input logic [15:0] p);
      int prod;
      prod = fold_a(p) * 25736;
`ifdef CORDIC_NCO_ROUND_EN
      prod = prod + 8192;
`endif
      prod = prod >>> 14;
      return prod[15:0];
   endfunction

   function automatic logic [15:0] nsat(input logic [15:0] v);
      int n;
      n = -int'($signed(v));
      if (n > 32767) n = 32767;
      return n[15:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid at edge %0d", edge_n);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.exp_edge != edge_n || bus.sin_out !== mon_e.s || bus.cos_out !== mon_e.c) begin
                  errors++;
                  $display("FAIL sb_out got edge %0d sin %h cos %h required edge %0d sin %h cos %h",
                           edge_n, bus.sin_out, bus.cos_out, mon_e.exp_edge, mon_e.s, mon_e.c);
               end
            end
         end else if (sb_q.size() > 0 && edge_n >= sb_q[0].exp_edge) begin
            checks++;
            errors++;
            mon_e = sb_q.pop_front();
            $display("FAIL missed_valid got out_valid 0 at edge %0d required 1 at edge %0d",
                     edge_n, mon_e.exp_edge);
         end
      end
   end

   task automatic step(input logic ld, input logic e, input logic [31:0] pi, input logic [31:0] inc);
      sb_t s;
      logic f;
      @(negedge clk);
      bus.load = ld; bus.en = e; bus.phase_init = pi; bus.phase_inc = inc;
      if (ld) begin
         m_phase = pi;
      end else if (e) begin
         m_theta    = model_theta(m_phase[31:16]);
         f          = fold_f(m_phase[31:16]);
         s.exp_edge = edge_n + 18;
         s.s        = f ? nsat(bus.sinx_raw) : bus.sinx_raw;
         s.c        = f ? nsat(bus.cosx_raw) : bus.cosx_raw;
         sb_q.push_back(s);
         m_phase    = m_phase + inc;
      end
      @(posedge clk);
      #1;
      chk("theta_in", bus.theta_in, m_theta);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         step(1'b0, 1'b0, 32'd0, 32'd0);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      sb_t s;
      tbl[0] = '{32'h2000_0000, 16'h2D41, 16'h2D41, 16'h3244, 16'h2D41, 16'h2D41};
      tbl[1] = '{32'hA000_0000, 16'h2D41, 16'h2D41, 16'h3244, 16'hD2BF, 16'hD2BF};
      tbl[2] = '{32'h6000_0000, 16'h1234, 16'h8000, 16'hCDBC, 16'hEDCC, 16'h7FFF};
      tbl[3] = '{32'h0000_0000, 16'h8000, 16'h4000, 16'h0000, 16'h8000, 16'h4000};
      tbl[4] = '{32'hC000_0000, 16'h7FFF, 16'h0001, 16'h9B78, 16'h7FFF, 16'h0001};
      tbl[5] = '{32'h4000_0000, 16'h8000, 16'h7FFF, 16'h9B78, 16'h7FFF, 16'h8001};
      tbl[6] = '{32'h3FFF_0000, 16'h0100, 16'hFF00, 16'h6486, 16'h0100, 16'hFF00};
      tbl[7] = '{32'hBFFF_0000, 16'h0100, 16'hFF00, 16'h6486, 16'hFF00, 16'h0100};

      bus.en = 1'b0; bus.load = 1'b0; bus.phase_init = '0; bus.phase_inc = '0;
      bus.sinx_raw = '0; bus.cosx_raw = '0;
      m_phase = '0; m_theta = '0;
      #3;
      chk("rst_theta", bus.theta_in, 16'h0000);
      chk("rst_x_in", bus.x_in, 16'h26DD);
      chk("rst_y_in", bus.y_in, 16'h0000);
      chk("rst_sin", bus.sin_out, 16'h0000);
      chk("rst_cos", bus.cos_out, 16'h0000);
      chk("rst_valid", {15'd0, bus.out_valid}, 16'h0000);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         bus.sinx_raw = tbl[i].sr;
         bus.cosx_raw = tbl[i].cr;
         step(1'b1, 1'b0, tbl[i].pinit, 32'd0);
         step(1'b0, 1'b1, 32'd0, 32'd0);
         chk("tbl_theta", bus.theta_in, tbl[i].et);
         s = sb_q.pop_back();
         s.s = tbl[i].es;
         s.c = tbl[i].ec;
         sb_q.push_back(s);
         drain();
      end

      // Wrap through zero
      bus.sinx_raw = 16'h1111; bus.cosx_raw = 16'h2222;
      step(1'b1, 1'b0, 32'hFFFF_0000, 32'd0);
      step(1'b0, 1'b1, 32'd0, 32'h0002_0000);
      chk("wrap_theta0", bus.theta_in, 16'hFFFE);
      step(1'b0, 1'b1, 32'd0, 32'h0002_0000);
`ifdef CORDIC_NCO_ROUND_EN
      chk("wrap_theta1", bus.theta_in, 16'h0002);
      step(1'b0, 1'b1, 32'd0, 32'd0);
      chk("wrap_phase", bus.theta_in, 16'h0005);
`else
      chk("wrap_theta1", bus.theta_in, 16'h0001);
      step(1'b0, 1'b1, 32'd0, 32'd0);
      chk("wrap_phase", bus.theta_in, 16'h0004);
`endif
      drain();

      // en gaps, then load colliding with en
      bus.sinx_raw = 16'h0123; bus.cosx_raw = 16'h0456;
      step(1'b1, 1'b0, 32'h0000_0000, 32'd0);
      step(1'b0, 1'b1, 32'd0, 32'h0100_0000);
      step(1'b0, 1'b0, 32'd0, 32'h0100_0000);
      step(1'b0, 1'b1, 32'd0, 32'h0100_0000);
      step(1'b0, 1'b1, 32'd0, 32'h0100_0000);
      drain();
      step(1'b1, 1'b1, 32'h2000_0000, 32'h0100_0000);
      step(1'b0, 1'b1, 32'd0, 32'd0);
      chk("load_pri_theta", bus.theta_in, 16'h3244);
      drain();

      // Reset mid-run with en held high
      bus.sinx_raw = 16'h0777; bus.cosx_raw = 16'h0888;
      step(1'b1, 1'b0, 32'h1000_0000, 32'd0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'd0, 32'h3000_0000);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      chk("mid_rst_theta", bus.theta_in, 16'h0000);
      chk("mid_rst_x_in", bus.x_in, 16'h26DD);
      chk("mid_rst_sin", bus.sin_out, 16'h0000);
      chk("mid_rst_cos", bus.cos_out, 16'h0000);
      chk("mid_rst_valid", {15'd0, bus.out_valid}, 16'h0000);
      sb_q.delete();
      m_phase = '0; m_theta = '0;
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         step(1'b0, 1'b1, 32'd0, 32'h3000_0000);
         chk("post_rst_valid_low", {15'd0, bus.out_valid}, 16'h0000);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
